// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_TGT,
        S_JALR_LNK,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    // Which kind of ALU operation the current state asks for.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_R,
        ALU_CLS_I
    } alu_class_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // funct3 010/011 are not real branches and are never taken.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mcu_aludec.sv
// ALU operation decode from instruction class and funct fields.
module mcu_aludec
    import mcu_pkg::*;
(
    input  alu_class_t  i_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    output alu_ctrl_t   o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_class)
            ALU_CLS_SUB: o_alu_ctrl = ALU_SUB;
            ALU_CLS_R, ALU_CLS_I: begin
                case (i_funct3)
                    // addi has no subtract form; funct7_5 there is immediate bits.
                    3'b000:  o_alu_ctrl = (i_class == ALU_CLS_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_ctrl = ALU_SLL;
                    3'b010:  o_alu_ctrl = ALU_SLT;
                    3'b011:  o_alu_ctrl = ALU_SLTU;
                    3'b100:  o_alu_ctrl = ALU_XOR;
                    3'b101:  o_alu_ctrl = i_funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_ctrl = ALU_OR;
                    default: o_alu_ctrl = ALU_AND;
                endcase
            end
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multicycle RV32I control FSM with memory ready handshake and optional timeout.
// Optional illegal-instruction trap state enabled by defining MCU_ILLEGAL_TRAP_EN.
module multicycle_controlunit
    import mcu_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       LtU,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       instr_done,
`ifdef MCU_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       bus_err
);

    localparam bit TO_EN = (WAIT_TIMEOUT > 0);
    localparam int CNT_W = TO_EN ? $clog2(WAIT_TIMEOUT + 1) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    logic       w_ready;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_we_ok;
    logic       w_pcw, w_irw, w_mw, w_rw, w_done;
    alu_class_t w_alu_class;
    alu_ctrl_t  w_alu_ctrl;
    imm_src_t   w_imm;

    assign w_ready     = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout   = TO_EN && w_mem_state && (r_cnt == CNT_W'(WAIT_TIMEOUT));
    // Write enables are suppressed on reset and on the timeout abort cycle.
    assign w_we_ok     = !rst && !w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_bus_err <= 1'b1;
        end else begin
            if (TO_EN && w_mem_state && !w_ready)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            case (r_state)
                S_FETCH:  if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_R:              r_state <= S_EXECR;
                        OP_I:              r_state <= S_EXECI;
`ifdef MCU_ILLEGAL_TRAP_EN
                        OP_BRANCH:         r_state <= (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
`else
                        OP_BRANCH:         r_state <= S_BRANCH;
`endif
                        OP_JAL:            r_state <= S_JAL;
                        OP_JALR:           r_state <= S_JALR_TGT;
                        OP_LUI:            r_state <= S_LUI;
                        OP_AUIPC:          r_state <= S_ALUWB;
`ifdef MCU_ILLEGAL_TRAP_EN
                        default:           r_state <= S_TRAP;
`else
                        default:           r_state <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
                S_MEMRD:    if (w_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWR:    if (w_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_JALR_TGT: r_state <= S_JALR_LNK;
                S_JALR_LNK: r_state <= S_FETCH;
                S_LUI:      r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    mcu_aludec u_aludec (
        .i_class    (w_alu_class),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_alu_ctrl (w_alu_ctrl)
    );

    always_comb begin
        w_pcw       = 1'b0;
        w_irw       = 1'b0;
        w_mw        = 1'b0;
        w_rw        = 1'b0;
        w_done      = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        w_imm       = IMM_I;
        w_alu_class = ALU_CLS_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                w_irw     = w_ready;
                w_pcw     = w_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_BRANCH: w_imm = IMM_B;
                    OP_JAL:    w_imm = IMM_J;
                    OP_AUIPC:  w_imm = IMM_U;
                    default:   w_imm = IMM_I;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_imm   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                w_rw      = 1'b1;
                w_done    = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_mw   = 1'b1;
                w_done = w_ready;
            end
            S_EXECR: begin
                ALUSrcA     = SRCA_RS1;
                w_alu_class = ALU_CLS_R;
            end
            S_EXECI: begin
                ALUSrcA     = SRCA_RS1;
                ALUSrcB     = SRCB_IMM;
                w_alu_class = ALU_CLS_I;
            end
            S_ALUWB: begin
                w_rw   = 1'b1;
                w_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_RS1;
                w_alu_class = ALU_CLS_SUB;
                w_pcw       = branch_taken(funct3, Zero, Lt, LtU);
                w_done      = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                w_pcw   = 1'b1;
            end
            S_JALR_TGT: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                w_pcw     = 1'b1;
            end
            // Link computed from OldPC so the target write cannot clobber it when rd==rs1.
            S_JALR_LNK: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                w_rw      = 1'b1;
                w_done    = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                w_imm   = IMM_U;
            end
            default: ;
        endcase
    end

    assign PCWrite    = w_pcw  & w_we_ok;
    assign IRWrite    = w_irw  & w_we_ok;
    assign MemWrite   = w_mw   & w_we_ok;
    assign RegWrite   = w_rw   & w_we_ok;
    assign instr_done = w_done & w_we_ok;
    assign ImmSrc     = w_imm;
    assign ALUControl = w_alu_ctrl;
    assign bus_err    = r_bus_err;
`ifdef MCU_ILLEGAL_TRAP_EN
    assign illegal    = (r_state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Scoreboard bench for multicycle_controlunit: expected output vectors are queued per cycle.
module tb_multicycle_controlunit;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       Zero = 1'b0, Lt = 1'b0, LtU = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, instr_done, bus_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int errors = 0;
    int checks = 0;

    logic [19:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    multicycle_controlunit #(.MEM_HANDSHAKE(1), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .Lt(Lt), .LtU(LtU), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done), .bus_err(bus_err)
    );

    // Vector layout: pcw adr irw mw rw | res | srcA | srcB | imm | alu | done | berr
    function automatic logic [19:0] V(input logic pcw, input logic adr, input logic irw,
                                      input logic mw, input logic rw, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] imm, input logic [3:0] alu,
                                      input logic done, input logic berr);
        return {pcw, adr, irw, mw, rw, res, sa, sb, imm, alu, done, berr};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, ALUControl, instr_done, bus_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (pcw adr irw mw rw res sa sb imm alu done berr)",
                         n, a, e);
            end
        end
    end

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        op = o; funct3 = f3; funct7_5 = f75;
    endtask

    // Drive one cycle of control inputs, optionally queue its expected outputs.
    task automatic step(input string nm, input logic r, input logic rdy, input logic chk,
                        input logic [19:0] e);
        rst = r;
        mem_ready = rdy;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input string nm, input logic [2:0] dec_imm, input logic berr);
        step({nm, "_fetch"}, 0, 1, 1, V(1,0,1,0,0,2'b10,2'b00,2'b10,3'b000,4'd0,0,berr));
        step({nm, "_dec"},   0, 1, 1, V(0,0,0,0,0,2'b00,2'b01,2'b01,dec_imm,4'd0,0,berr));
    endtask

    task automatic run_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f75, input logic [1:0] sb, input logic [3:0] alu);
        set_instr(o, f3, f75);
        fetch_dec(nm, 3'b000, 0);
        step({nm, "_exec"}, 0, 1, 1, V(0,0,0,0,0,2'b00,2'b10,sb,3'b000,alu,0,0));
        step({nm, "_wb"},   0, 1, 1, V(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd0,1,0));
    endtask

    task automatic run_br(input string nm, input logic [2:0] f3, input logic z,
                          input logic lt, input logic ltu, input logic taken);
        set_instr(T_BRANCH, f3, 0);
        Zero = z; Lt = lt; LtU = ltu;
        fetch_dec(nm, 3'b010, 0);
        step({nm, "_br"}, 0, 1, 1, V(taken,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd1,1,0));
        Zero = 0; Lt = 0; LtU = 0;
    endtask

    initial begin
        step("rst0", 1, 1, 0, '0);
        step("rst_state", 1, 1, 1, V(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'd0,0,0));

        run_alu("add",   T_R, 3'b000, 0, 2'b00, 4'd0);
        run_alu("sub",   T_R, 3'b000, 1, 2'b00, 4'd1);
        run_alu("srai",  T_I, 3'b101, 1, 2'b01, 4'd9);
        run_alu("addi7", T_I, 3'b000, 1, 2'b01, 4'd0);
        run_alu("and",   T_R, 3'b111, 0, 2'b00, 4'd2);

        // Load with three wait cycles in MEMRD
        set_instr(T_LOAD, 3'b010, 0);
        fetch_dec("lw", 3'b000, 0);
        step("lw_adr", 0, 1, 1, V(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'd0,0,0));
        for (int i = 0; i < 3; i++)
            step("lw_rd_wait", 0, 0, 1, V(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0,0));
        step("lw_rd", 0, 1, 1, V(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0,0));
        step("lw_wb", 0, 1, 1, V(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'd0,1,0));

        run_br("bge_nt0", 3'b101, 0, 0, 0, 1);
        run_br("bge_lt1", 3'b101, 0, 1, 0, 0);
        run_br("beq_z1",  3'b000, 1, 0, 0, 1);
        run_br("bne_z1",  3'b001, 1, 0, 0, 0);
        run_br("bltu",    3'b110, 0, 0, 1, 1);
        run_br("br_f010", 3'b010, 1, 1, 1, 0);

        set_instr(T_JAL, 3'b000, 0);
        fetch_dec("jal", 3'b011, 0);
        step("jal_pc", 0, 1, 1, V(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,4'd0,0,0));
        step("jal_wb", 0, 1, 1, V(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd0,1,0));

        set_instr(T_JALR, 3'b000, 0);
        fetch_dec("jalr", 3'b000, 0);
        step("jalr_tgt", 0, 1, 1, V(1,0,0,0,0,2'b10,2'b10,2'b01,3'b000,4'd0,0,0));
        step("jalr_lnk", 0, 1, 1, V(0,0,0,0,1,2'b10,2'b01,2'b10,3'b000,4'd0,1,0));

        set_instr(T_LUI, 3'b000, 0);
        fetch_dec("lui", 3'b000, 0);
        step("lui_ex", 0, 1, 1, V(0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,4'd0,0,0));
        step("lui_wb", 0, 1, 1, V(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd0,1,0));

        set_instr(T_AUIPC, 3'b000, 0);
        fetch_dec("auipc", 3'b100, 0);
        step("auipc_wb", 0, 1, 1, V(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd0,1,0));

        // Store completing immediately
        set_instr(T_STORE, 3'b010, 0);
        fetch_dec("sw", 3'b000, 0);
        step("sw_adr", 0, 1, 1, V(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'd0,0,0));
        step("sw_wr",  0, 1, 1, V(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,4'd0,1,0));

        // Store with ready stuck low: four write cycles, then abort with bus_err
        fetch_dec("swto", 3'b000, 0);
        step("swto_adr", 0, 1, 1, V(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'd0,0,0));
        for (int i = 0; i < 4; i++)
            step("swto_wait", 0, 0, 1, V(0,1,0,1,0,2'b00,2'b00,2'b00,3'b000,4'd0,0,0));
        step("swto_abort", 0, 0, 1, V(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0,0));

        // Unknown opcode acts as a NOP; bus_err stays set
        set_instr(7'b0000000, 3'b000, 0);
        fetch_dec("nop", 3'b000, 1);

        // Reset while in MEMWR
        set_instr(T_STORE, 3'b010, 0);
        fetch_dec("swrst", 3'b000, 1);
        step("swrst_adr", 0, 1, 1, V(0,0,0,0,0,2'b00,2'b10,2'b01,3'b001,4'd0,0,1));
        step("swrst_rst", 1, 0, 1, V(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0,1));
        set_instr(T_R, 3'b000, 0);
        fetch_dec("post_rst", 3'b000, 0);

        step("drain0", 0, 1, 0, '0);
        step("drain1", 0, 1, 0, '0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controlunit.md
Name: multicycle_controlunit

Overview:
- Multicycle RV32I control FSM. Successor to the single-cycle control decoder: one instruction is spread over 3-5 states, sharing one ALU and one unified instruction/data memory port.
- Adds full branch set (beq/bne/blt/bge/bltu/bgeu), jal/jalr/lui/auipc, and a 10-op ALU.
- Adds a memory ready handshake with optional timeout.
- Sits between the instruction register/flags and the multicycle datapath muxes and enables.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = memory assumed single-cycle and mem_ready ignored.
- WAIT_TIMEOUT, 0, cycles a memory state may wait before bus_err. 0 disables the timeout. Counter width is $clog2(WAIT_TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- Zero  in  1  ALU result == 0
- Lt  in  1  signed A<B from ALU
- LtU  in  1  unsigned A<B from ALU
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address
- IRWrite  out  1  IR and OldPC enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A(rs1), 11 zero
- ALUSrcB  out  2  00 B(rs2), 01 imm, 10 const 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- instr_done  out  1  one-cycle pulse on the last state of each instruction
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On the clk edge with rst high: state <= FETCH, wait counter <= 0, bus_err <= 0. While rst is high, PCWrite, IRWrite, MemWrite, RegWrite and instr_done are forced to 0.
- Output style: Moore outputs decoded from state. Exceptions are ImmSrc, ALUControl and branch PCWrite, which also use op/funct/flags. Unlisted outputs are 0; ALUControl defaults to add.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite = PCWrite = ready. Go to DECODE when ready, otherwise stay. "ready" is mem_ready, or 1 when MEM_HANDSHAKE=0.
- DECODE: ALUSrcA=01, ALUSrcB=01, add, so ALUOut = OldPC + imm. ImmSrc is B for branch, J for jal, U for auipc.
- DECODE dispatch:
  - load/store -> MEMADR
  - R -> EXECR; OP-IMM -> EXECI
  - branch -> BRANCH
  - jal -> JAL; jalr -> JALR_TGT
  - lui -> LUI; auipc -> ALUWB
  - anything else -> FETCH (treated as NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc I for loads and S for stores. Loads go to MEMRD, stores to MEMWR.
- MEMRD: AdrSrc=1. Go to MEMWB when ready, otherwise stay.
- MEMWB: ResultSrc=01, RegWrite, instr_done. Then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1. Go to FETCH when ready, otherwise stay; instr_done on the exit cycle.
- EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc I. Both then go to ALUWB.
- ALU decode (EXECR/EXECI):
  - funct3 000: sub only for R with funct7_5=1; addi is always add.
  - funct3 101: sra if funct7_5=1, otherwise srl, for both R and I.
- ALUWB: ResultSrc=00, RegWrite, instr_done. Then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = taken, then FETCH; instr_done. Taken by funct3:
  - 000 Zero; 001 ~Zero
  - 100 Lt; 101 ~Lt
  - 110 LtU; 111 ~LtU
  - 010/011: never taken
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite. Then ALUWB, which writes rd = PC+4.
- JALR_TGT: ALUSrcA=10, ALUSrcB=01, ImmSrc I, ResultSrc=10, PCWrite. Then JALR_LNK.
- JALR_LNK: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite, instr_done. Then FETCH. The link uses OldPC, so rd==rs1 is safe.
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc U. Then ALUWB.
- Timeout (WAIT_TIMEOUT>0):
  - The counter increments each cycle a memory state waits with ready=0, and clears on state exit.
  - When the counter reaches WAIT_TIMEOUT: set bus_err and go to FETCH. No write enables fire that cycle.
  - bus_err clears only on rst.
- Reset mid-instruction: abandons the instruction; no partial write occurs on the reset cycle.

Optional Feature:
- Macro: MCU_ILLEGAL_TRAP_EN.
- Defined: unknown opcodes, and branch funct3 010/011, go to TRAP.
  - TRAP drives all enables to 0 and holds until rst.
  - Adds output illegal (1 bit), high in TRAP.
- Undefined: these cases act as NOP as described above; the illegal port is absent.

Decomposition:
- Package mcu_pkg holds:
  - state_t enum
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - alu_ctrl_t, imm_src_t, and the src-select encodings
- Sub-module mcu_aludec: combinational funct3/funct7_5/instr-class to ALUControl decode.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0) after reset -> FETCH, DECODE, EXECR, ALUWB. ALUControl=0 in EXECR; RegWrite only in ALUWB; instr_done once; 4 cycles.
- lw with mem_ready low for 3 cycles in MEMRD, WAIT_TIMEOUT=0 -> MEMRD held 3 extra cycles, then MEMWB with ResultSrc=01; 5+3 cycles total.
- bge (f3 101) with Lt=0, then with Lt=1 -> PCWrite=1 in BRANCH for the first, 0 for the second; 3 cycles each.
- jalr -> JALR_TGT (PCWrite, ResultSrc=10), then JALR_LNK (RegWrite, ALUSrcA=01, ALUSrcB=10).
- WAIT_TIMEOUT=4, sw with mem_ready stuck low -> MemWrite high 4 cycles, bus_err=1, back in FETCH with no RegWrite; bus_err holds until rst.
- rst asserted during MEMWR -> MemWrite=0 on that cycle; next state FETCH; bus_err=0.
